// File: rtl/ysyx_25060170_wbu_stage.sv
// Writeback stage: selects and aligns the result, queues it in a small FIFO,
// and drains one entry per cycle into the register file with commit reporting.
module ysyx_25060170_wbu_stage #(
  parameter int XLEN  = 32,
  parameter int RAW   = 5,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] exu_result_i,
  input  logic [XLEN-1:0] mem_data_i,
  input  logic [XLEN-1:0] csr_data_i,
  input  logic [RAW-1:0]  rd_i,
  input  logic [1:0]      regS,
  input  logic            RegW,
  input  logic [2:0]      load_fmt,
  input  logic [2:0]      addr_lo,
  input  logic            wb_ready,
  output logic            reg_write_en_o,
  output logic [RAW-1:0]  reg_write_addr_o,
  output logic [XLEN-1:0] reg_write_data_o,
  output logic            commit_valid_o,
  output logic [XLEN-1:0] commit_pc_o,
  input  logic [RAW-1:0]  fwd_addr_i,
  output logic            fwd_hit_o,
  output logic [XLEN-1:0] fwd_data_o,
  output logic [63:0]     retire_cnt_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [RAW-1:0]  rd;
    logic [XLEN-1:0] data;
    logic            regw;
  } entry_t;

  entry_t          fifo_q [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;

  logic            full;
  logic            live;
  logic            push;
  logic            pop;
  entry_t          head;
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] load_val;
  logic [XLEN-1:0] wb_data;

  // in_ready depends on registered state (and reset) only, never on wb_ready.
  assign full     = (count == CW'(DEPTH));
  assign live     = !rst && (count != '0);
  assign in_ready = rst || !full;
  assign push     = in_valid && in_ready && !rst;
  assign pop      = live && wb_ready;
  assign head     = fifo_q[rd_ptr];

  assign shifted = mem_data_i >> {addr_lo, 3'b000};

  // NOTE: every combinational output gets a default before the case so no latch is inferred.
  always_comb begin
    load_val = '0;
    case (load_fmt)
      3'd0: load_val = XLEN'($signed(shifted[7:0]));
      3'd1: load_val = XLEN'($signed(shifted[15:0]));
      3'd2: load_val = XLEN'($signed(shifted[31:0]));
      3'd3: load_val = (XLEN == 64) ? shifted : '0;
      3'd4: load_val = XLEN'(shifted[7:0]);
      3'd5: load_val = XLEN'(shifted[15:0]);
      default: load_val = '0;
    endcase
  end

  always_comb begin
    wb_data = exu_result_i;
    case (regS)
      2'd0: wb_data = exu_result_i;
      2'd1: wb_data = load_val;
      2'd2: wb_data = pc_i + XLEN'(4);
      2'd3: wb_data = csr_data_i;
      default: wb_data = exu_result_i;
    endcase
  end

  // NOTE: the entry storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr] <= '{pc: pc_i, rd: rd_i, data: wb_data, regw: RegW};
    end
  end

  // NOTE: sequential state uses non-blocking assignments; combinational blocks use blocking.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      retire_cnt_o <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) begin
        rd_ptr       <= rd_ptr + PW'(1);
        retire_cnt_o <= retire_cnt_o + 64'd1;
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign reg_write_en_o   = pop && head.regw && (head.rd != '0);
  assign reg_write_addr_o = live ? head.rd   : '0;
  assign reg_write_data_o = live ? head.data : '0;
  assign commit_valid_o   = pop;
  assign commit_pc_o      = live ? head.pc   : '0;

  // Walk oldest to youngest so the last match is the youngest producer.
  always_comb begin
    fwd_hit_o  = 1'b0;
    fwd_data_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!rst && (i < int'(count)) && fifo_q[rd_ptr + PW'(i)].regw &&
          (fifo_q[rd_ptr + PW'(i)].rd == fwd_addr_i) && (fwd_addr_i != '0)) begin
        fwd_hit_o  = 1'b1;
        fwd_data_o = fifo_q[rd_ptr + PW'(i)].data;
      end
    end
  end

endmodule
